wordle_entry_keyboard: RTL and testbench
========================================

# wordle_entry_keyboard

Parametrised on-screen keyboard navigator with guess-entry buffer. Drives the cursor over a configurable grid of letter keys from U/D/L/R button pulses, optionally wraps at grid edges, and assembles typed letters into a WORD_LEN-letter guess with backspace and submit. Sits between the debounced button conditioner and the game-logic/scoring block, replacing the fixed 10/10/6 cursor-only keyboard.

## Interface
- NUM_COLS, 10: keys per full row (2..16)
- NUM_ROWS, 3: row count (2..4)
- LAST_ROW_LEN, 6: keys in last row (1..NUM_COLS); total keys ≤ 32
- WORD_LEN, 5: letters per guess (1..8)
- WRAP, 0: 1 = cursor wraps at edges, 0 = cursor clamps
- Clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- Start  in  1  QI→QRUN request
- Ack  in  1  QDONE→QI acknowledge
- U, D, L, R, C  in  1  single-cycle debounced pulses; C = select key
- Bksp  in  1  single-cycle pulse, delete last letter
- Enter  in  1  single-cycle pulse, submit guess
- q_I, q_Run, q_Done  out  1 each  one-hot state
- row_curr  out  max(1,clog2(NUM_ROWS))  cursor row
- col_curr  out  clog2(NUM_COLS)  cursor column
- curr_letter  out  5  key index row*NUM_COLS+col (0 = 'A'), combinational from row/col
- guess  out  5*WORD_LEN  letter i at guess[5*i +: 5], i=0 first typed
- guess_len  out  clog2(WORD_LEN+1)  letters held
- reject  out  1  one-cycle pulse on an ignored C/Enter/Bksp

## Operation
- States: QI (100), QRUN (010), QDONE (001). Illegal encodings → QI next edge.
- QI: Start → QRUN; row, col, guess, guess_len cleared on the same edge. All navigation/entry inputs ignored.
- QRUN: at most one action per cycle, priority U > D > L > R > C > Bksp > Enter; lower-priority pulses in the same cycle are dropped.
- Row length: rows 0..NUM_ROWS-2 have NUM_COLS keys; last row has LAST_ROW_LEN.
- U/D, WRAP=0: row ±1 unless at row 0 / last row (no change). WRAP=1: row 0 U → last row; last row D → row 0.
- Any row change into the last row with col ≥ LAST_ROW_LEN clamps col to LAST_ROW_LEN-1.
- L/R, WRAP=0: col ±1 within row length, stop at ends. WRAP=1: col 0 L → row length-1; row end R → col 0; row unchanged.
- C: guess_len < WORD_LEN → guess slot guess_len ← curr_letter, guess_len+1. Full → reject, no change.
- Bksp: guess_len > 0 → slot guess_len-1 ← 0, guess_len-1. Empty → reject.
- Enter: guess_len == WORD_LEN → QDONE. Otherwise reject, stay QRUN.
- QDONE: guess, guess_len, cursor frozen; all inputs except Ack ignored (no reject). Ack → QI; guess contents held until next Start.
- Reset: state QI, row 0, col 0, guess all 0, guess_len 0, reject 0.

## Timing
- All outputs except curr_letter are registered; an input pulse present at rising edge k is reflected in outputs after edge k (1-cycle latency). curr_letter follows row/col combinationally.
- reject is high exactly the cycle after the offending edge, for one cycle.
- Start and navigation pulse coincident in QI: only the transition happens; navigation ignored.
- Held (multi-cycle) input acts once per cycle; debouncing/one-shotting is the upstream block's job.
- Reset asserted mid-QRUN or QDONE: all registers return to reset values immediately (asynchronous), independent of Clk.

## Test plan
- Defaults, reset then Start, R×3, D×1, C → row_curr=1, col_curr=3, curr_letter=13 ('N'), guess_len=1, guess[4:0]=13.
- WRAP=0: at (0,9) press D twice → (2,5) after clamp, curr_letter=25 ('Z'); further R, D → no change.
- WRAP=1: at (0,0) press L → (0,9); U → (2,5) clamped; D → (0,5); R at (2,5) → (2,0).
- Type C×5 then C again → guess_len=5, reject pulse 1 cycle, guess unchanged; Bksp → guess_len=4, guess[24:20]=0.
- Enter with guess_len=3 → reject, stay QRUN; fill to 5, Enter → q_Done=1, guess held; Ack → q_I=1; Start → guess=0, cursor (0,0).
- U and C in same cycle in QRUN → only row moves, guess_len unchanged; reset pulse mid-entry → q_I=1, guess=0 without a clock edge.

Source files
------------

// File: rtl/wordle_entry_keyboard.sv
// rtl/wordle_entry_keyboard.sv - on-screen keyboard cursor navigator with guess-entry buffer
module wordle_entry_keyboard #(
    parameter int NUM_COLS     = 10,
    parameter int NUM_ROWS     = 3,
    parameter int LAST_ROW_LEN = 6,
    parameter int WORD_LEN     = 5,
    parameter int WRAP         = 0,
    localparam int RW = (NUM_ROWS > 2) ? $clog2(NUM_ROWS) : 1,
    localparam int CW = $clog2(NUM_COLS),
    localparam int LW = $clog2(WORD_LEN + 1)
) (
    input  logic                  Clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic                  Ack,
    input  logic                  U,
    input  logic                  D,
    input  logic                  L,
    input  logic                  R,
    input  logic                  C,
    input  logic                  Bksp,
    input  logic                  Enter,
    output logic                  q_I,
    output logic                  q_Run,
    output logic                  q_Done,
    output logic [RW-1:0]         row_curr,
    output logic [CW-1:0]         col_curr,
    output logic [4:0]            curr_letter,
    output logic [5*WORD_LEN-1:0] guess,
    output logic [LW-1:0]         guess_len,
    output logic                  reject
);

    typedef enum logic [2:0] {
        QI    = 3'b100,
        QRUN  = 3'b010,
        QDONE = 3'b001
    } state_t;

    localparam logic [RW-1:0] LAST_ROW = RW'(NUM_ROWS - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [CW-1:0] LAST_COL = CW'(LAST_ROW_LEN - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [LW-1:0] LEN_ONE  = LW'(1);

    state_t                  state_q, state_d;
    logic [RW-1:0]           row_q, row_d;
    logic [CW-1:0]           col_q, col_d;
    logic [5*WORD_LEN-1:0]   guess_q, guess_d;
    logic [LW-1:0]           len_q, len_d;
    logic                    reject_q, reject_d;

    // Key index under the cursor; fits 5 bits because total keys never exceed 32
    assign curr_letter = 5'(row_q) * 5'(NUM_COLS) + 5'(col_q);

    assign q_I       = state_q[2];
    assign q_Run     = state_q[1];
    assign q_Done    = state_q[0];
    assign row_curr  = row_q;
    assign col_curr  = col_q;
    assign guess     = guess_q;
    assign guess_len = len_q;
    assign reject    = reject_q;

    // Next-state: one prioritised action per cycle in QRUN, U > D > L > R > C > Bksp > Enter
    always_comb begin
        int row_len;
        int idx;
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        guess_d  = guess_q;
        len_d    = len_q;
        reject_d = 1'b0;
        row_len  = (row_q == LAST_ROW) ? LAST_ROW_LEN : NUM_COLS;
        idx      = 0;
        case (state_q)
            QI: begin
                if (Start) begin
                    state_d = QRUN;
                    row_d   = '0;
                    col_d   = '0;
                    guess_d = '0;
                    len_d   = '0;
                end
            end
            QRUN: begin
                if (U) begin
                    if (row_q != '0)     row_d = row_q - ROW_ONE;
                    else if (WRAP != 0)  row_d = LAST_ROW;
                end else if (D) begin
                    if (row_q != LAST_ROW) row_d = row_q + ROW_ONE;
                    else if (WRAP != 0)    row_d = '0;
                end else if (L) begin
                    if (col_q != '0)     col_d = col_q - COL_ONE;
                    else if (WRAP != 0)  col_d = CW'(row_len - 1);
                end else if (R) begin
                    if (int'(col_q) != row_len - 1) col_d = col_q + COL_ONE;
                    else if (WRAP != 0)             col_d = '0;
                end else if (C) begin
                    if (int'(len_q) < WORD_LEN) begin
                        idx = 5 * int'(len_q);
                        guess_d[idx +: 5] = curr_letter;
                        len_d = len_q + LEN_ONE;
                    end else begin
                        reject_d = 1'b1;
                    end
                end else if (Bksp) begin
                    if (len_q != '0) begin
                        idx = 5 * (int'(len_q) - 1);
                        guess_d[idx +: 5] = 5'd0;
                        len_d = len_q - LEN_ONE;
                    end else begin
                        reject_d = 1'b1;
                    end
                end else if (Enter) begin
                    if (int'(len_q) == WORD_LEN) state_d = QDONE;
                    else                         reject_d = 1'b1;
                end
                // The short last row cannot hold a column beyond its end
                if ((U || D) && row_d == LAST_ROW && int'(col_q) >= LAST_ROW_LEN)
                    col_d = LAST_COL;
            end
            QDONE: begin
                if (Ack) state_d = QI;
            end
            default: state_d = QI;
        endcase
    end

    // State registers with asynchronous clear
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q  <= QI;
            row_q    <= '0;
            col_q    <= '0;
            guess_q  <= '0;
            len_q    <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            guess_q  <= guess_d;
            len_q    <= len_d;
            reject_q <= reject_d;
        end
    end

endmodule

// File: tb/tb_wordle_entry_keyboard.sv
// tb/tb_wordle_entry_keyboard.sv - table-driven bench for wordle_entry_keyboard
module tb_wordle_entry_keyboard;

    localparam logic [8:0] IU = 9'h001, ID = 9'h002, IL = 9'h004, IR = 9'h008, IC = 9'h010,
                           IB = 9'h020, IE = 9'h040, IS = 9'h080, IA = 9'h100, INONE = 9'h000;
    localparam logic [2:0] SI = 3'b100, SR = 3'b010, SD = 3'b001;

    logic Clk = 1'b0, reset = 1'b0;
    logic Start = 0, Ack = 0, U = 0, D = 0, L = 0, R = 0, C = 0, Bksp = 0, Enter = 0;

    logic       o0_i, o0_r, o0_d, o0_rej, o1_i, o1_r, o1_d, o1_rej;
    logic [1:0] o0_row, o1_row;
    logic [3:0] o0_col, o1_col;
    logic [4:0] o0_let, o1_let;
    logic [24:0] o0_g, o1_g;
    logic [2:0] o0_len, o1_len;

    int tests = 0, fails = 0;

    always #5 Clk = ~Clk;

    wordle_entry_keyboard #(.WRAP(0)) dut0 (
        .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack), .U(U), .D(D), .L(L), .R(R), .C(C),
        .Bksp(Bksp), .Enter(Enter), .q_I(o0_i), .q_Run(o0_r), .q_Done(o0_d), .row_curr(o0_row),
        .col_curr(o0_col), .curr_letter(o0_let), .guess(o0_g), .guess_len(o0_len), .reject(o0_rej));

    wordle_entry_keyboard #(.WRAP(1)) dut1 (
        .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack), .U(U), .D(D), .L(L), .R(R), .C(C),
        .Bksp(Bksp), .Enter(Enter), .q_I(o1_i), .q_Run(o1_r), .q_Done(o1_d), .row_curr(o1_row),
        .col_curr(o1_col), .curr_letter(o1_let), .guess(o1_g), .guess_len(o1_len), .reject(o1_rej));

    typedef struct {
        logic [8:0]  in;
        logic [2:0]  st;
        int          row;
        int          col;
        int          len;
        logic        rej;
        logic [24:0] g;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic [8:0] in);
        {Ack, Start, Enter, Bksp, C, R, L, D, U} = in;
        @(posedge Clk);
        #1;
        {Ack, Start, Enter, Bksp, C, R, L, D, U} = '0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    function automatic vec_t mk(logic [8:0] in, logic [2:0] st, int row, int col, int len,
                                logic rej, logic [24:0] g);
        vec_t v;
        v.in = in; v.st = st; v.row = row; v.col = col; v.len = len; v.rej = rej; v.g = g;
        return v;
    endfunction

    logic [24:0] eg;

    initial begin
        vecs[0]  = mk(IR,      SI, 0, 0, 0, 0, 25'd0);
        vecs[1]  = mk(IS | IR, SR, 0, 0, 0, 0, 25'd0);
        vecs[2]  = mk(IR,      SR, 0, 1, 0, 0, 25'd0);
        vecs[3]  = mk(IR,      SR, 0, 2, 0, 0, 25'd0);
        vecs[4]  = mk(IR,      SR, 0, 3, 0, 0, 25'd0);
        vecs[5]  = mk(ID,      SR, 1, 3, 0, 0, 25'd0);
        vecs[6]  = mk(IC,      SR, 1, 3, 1, 0, 25'd13);
        vecs[7]  = mk(IU | IC, SR, 0, 3, 1, 0, 25'd13);
        vecs[8]  = mk(IL,      SR, 0, 2, 1, 0, 25'd13);
        vecs[9]  = mk(IL,      SR, 0, 1, 1, 0, 25'd13);
        vecs[10] = mk(IL,      SR, 0, 0, 1, 0, 25'd13);
        vecs[11] = mk(IL,      SR, 0, 0, 1, 0, 25'd13);
        vecs[12] = mk(IU,      SR, 0, 0, 1, 0, 25'd13);
        vecs[13] = mk(IC,      SR, 0, 0, 2, 0, 25'd13);
        vecs[14] = mk(IB,      SR, 0, 0, 1, 0, 25'd13);
        vecs[15] = mk(IB,      SR, 0, 0, 0, 0, 25'd0);
        vecs[16] = mk(IB,      SR, 0, 0, 0, 1, 25'd0);
        vecs[17] = mk(IE,      SR, 0, 0, 0, 1, 25'd0);
        vecs[18] = mk(IA,      SR, 0, 0, 0, 0, 25'd0);
        vecs[19] = mk(ID | IR, SR, 1, 0, 0, 0, 25'd0);

        // Reset state
        reset = 1'b1;
        #12;
        reset = 1'b0;
        #1;
        chk("rst_state", {o0_i, o0_r, o0_d}, SI);
        chk("rst_rowcol", {o0_row, o0_col}, 0);
        chk("rst_guess", o0_g, 0);
        chk("rst_len", o0_len, 0);
        chk("rst_reject", o0_rej, 0);
        chk("rst_state_w", {o1_i, o1_r, o1_d}, SI);

        // Table-driven sequence on the clamping instance
        for (int i = 0; i < 20; i++) begin
            step(vecs[i].in);
            chk($sformatf("v%0d_state", i), {o0_i, o0_r, o0_d}, vecs[i].st);
            chk($sformatf("v%0d_row", i), o0_row, vecs[i].row);
            chk($sformatf("v%0d_col", i), o0_col, vecs[i].col);
            chk($sformatf("v%0d_len", i), o0_len, vecs[i].len);
            chk($sformatf("v%0d_rej", i), o0_rej, vecs[i].rej);
            chk($sformatf("v%0d_guess", i), o0_g, vecs[i].g);
        end

        // Clamp at grid edges and into the short last row
        do_reset();
        step(IS);
        repeat (9) step(IR);
        chk("cl_0_9", {o0_row, o0_col}, {2'd0, 4'd9});
        step(IR);
        chk("cl_r_end", {o0_row, o0_col}, {2'd0, 4'd9});
        step(ID);
        chk("cl_1_9", {o0_row, o0_col}, {2'd1, 4'd9});
        step(ID);
        chk("cl_2_5", {o0_row, o0_col}, {2'd2, 4'd5});
        chk("cl_letter", o0_let, 25);
        step(IR);
        chk("cl_r_last", {o0_row, o0_col}, {2'd2, 4'd5});
        step(ID);
        chk("cl_d_last", {o0_row, o0_col}, {2'd2, 4'd5});

        // Wrapping instance
        do_reset();
        step(IS);
        step(IL);
        chk("wr_l", {o1_row, o1_col}, {2'd0, 4'd9});
        step(IU);
        chk("wr_u_clamp", {o1_row, o1_col}, {2'd2, 4'd5});
        step(ID);
        chk("wr_d", {o1_row, o1_col}, {2'd0, 4'd5});
        step(IU);
        chk("wr_u", {o1_row, o1_col}, {2'd2, 4'd5});
        step(IR);
        chk("wr_r_last", {o1_row, o1_col}, {2'd2, 4'd0});
        step(IL);
        chk("wr_l_last", {o1_row, o1_col}, {2'd2, 4'd5});

        // Fill, overflow, backspace, submit, acknowledge, restart
        do_reset();
        step(IS);
        eg = '0;
        for (int i = 0; i < 5; i++) begin
            step(IC);
            step(IR);
            eg[5*i +: 5] = 5'(i);
        end
        chk("fill_len", o0_len, 5);
        chk("fill_guess", o0_g, eg);
        step(IC);
        chk("over_rej", o0_rej, 1);
        chk("over_len", o0_len, 5);
        chk("over_guess", o0_g, eg);
        step(INONE);
        chk("over_rej_1cyc", o0_rej, 0);
        step(IB);
        eg[24:20] = 5'd0;
        chk("bk_len", o0_len, 4);
        chk("bk_guess", o0_g, eg);
        step(IB);
        eg[19:15] = 5'd0;
        step(IE);
        chk("ent3_rej", o0_rej, 1);
        chk("ent3_state", {o0_i, o0_r, o0_d}, SR);
        step(IC);
        step(IC);
        eg[19:15] = 5'd5;
        eg[24:20] = 5'd5;
        chk("refill_guess", o0_g, eg);
        step(IE);
        chk("done_state", {o0_i, o0_r, o0_d}, SD);
        chk("done_rej", o0_rej, 0);
        step(IC);
        chk("done_c_rej", o0_rej, 0);
        chk("done_c_len", o0_len, 5);
        step(IL);
        chk("done_frozen", o0_col, 5);
        step(IA);
        chk("ack_state", {o0_i, o0_r, o0_d}, SI);
        chk("ack_guess", o0_g, eg);
        step(IS);
        chk("restart_state", {o0_i, o0_r, o0_d}, SR);
        chk("restart_guess", o0_g, 0);
        chk("restart_rowcol", {o0_row, o0_col}, 0);
        chk("restart_len", o0_len, 0);

        // Asynchronous reset mid-entry
        step(IR);
        step(IC);
        chk("pre_rst_guess", o0_g, 1);
        @(negedge Clk);
        reset = 1'b1;
        #1;
        chk("arst_state", {o0_i, o0_r, o0_d}, SI);
        chk("arst_guess", o0_g, 0);
        chk("arst_len", o0_len, 0);
        chk("arst_col", o0_col, 0);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
